// File: rtl/cpu_ctrl.sv
// Control/sequencer core: phase counter, PC, prioritised vectored interrupts,
// write stall on busy I/O and I/O register sampling at commit.
module cpu_ctrl #(
  parameter int unsigned     PC_W     = 11,
  parameter int unsigned     DATA_W   = 8,
  parameter int unsigned     PHASES   = 4,
  parameter int unsigned     N_IRQ    = 4,
  parameter logic [PC_W-1:0] VEC_BASE = PC_W'('h010)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq,
  output logic [N_IRQ-1:0]  irq_ack,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_reti,
  input  logic              ex_ien_we,
  input  logic              ex_ien,
  input  logic              ex_w_req,
  input  logic [DATA_W-1:0] ex_w_data,
  output logic              w_req,
  output logic [DATA_W-1:0] w_data,
  input  logic              w_busy,
  input  logic [DATA_W-1:0] r_data,
  output logic              commit,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   intr_pc,
  output logic [2:0]        intr_vec,
  output logic              intr_en,
  output logic [DATA_W-1:0] r_data_q,
  output logic              w_busy_q,
  output logic [N_IRQ-1:0]  pending
);

  logic [PHASES-1:0] phase;
  logic [N_IRQ-1:0]  irq_d;
  logic [N_IRQ-1:0]  clear;
  logic              commit_slot;
  logic              stall;
  logic              take;
  logic [2:0]        idx;
  logic [PC_W-1:0]   vec_pc;

  assign rom_addr = pc;

  // Slot qualification, stall, and lowest-index priority select.
  always_comb begin
    commit_slot = phase[0] & ~reset;
    stall       = commit_slot & ex_w_req & w_busy;
    commit      = commit_slot & ~stall;
    w_req       = commit & ex_w_req;
    w_data      = reset ? '0 : ex_w_data;
    take        = commit & intr_en & ~ex_reti & (|pending);
    idx         = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (pending[i]) idx = 3'(i);
    end
    clear   = take ? (N_IRQ'(1) << idx) : '0;
    irq_ack = clear;
    vec_pc  = VEC_BASE + (PC_W'(idx) << 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= PHASES'(1);
      irq_d    <= '0;
      pending  <= '0;
      pc       <= '0;
      intr_pc  <= '0;
      intr_vec <= '0;
      intr_en  <= 1'b0;
      r_data_q <= '0;
      w_busy_q <= 1'b0;
    end else begin
      irq_d   <= irq;
      // A fresh edge in the clearing cycle wins over the clear.
      pending <= (pending & ~clear) | (irq & ~irq_d);
      if (!stall) phase <= {phase[PHASES-2:0], phase[PHASES-1]};
      if (commit) begin
        r_data_q <= r_data;
        w_busy_q <= w_busy;
        if (ex_reti) begin
          pc      <= intr_pc;
          intr_en <= 1'b1;
        end else if (take) begin
          pc       <= vec_pc;
          intr_pc  <= ex_pc;
          intr_en  <= 1'b0;
          intr_vec <= idx;
        end else begin
          pc <= ex_pc;
          if (ex_ien_we) intr_en <= ex_ien;
        end
      end
    end
  end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Parametrised control/sequencer core for the CPU: owns the instruction-phase counter, PC, interrupt state and the I/O register sampling.
- Successor to the fixed 4-phase, single-interrupt sequencer.
  - Adds a configurable phase count.
  - Adds N prioritised, edge-latched interrupt channels with vectoring.
  - Adds a write-stall on busy I/O.
- Sits between ROM/I-O pins and the execute stage (alu), which supplies next-state requests.

Parameters:
PC_W, 11, PC / rom_addr width
DATA_W, 8, I/O data width
PHASES, 4, clocks per instruction (>=2); commit occurs once per PHASES cycles
N_IRQ, 4, interrupt channels (1..8), channel 0 highest priority
VEC_BASE, 11'h010, PC of channel-0 handler; channel i handler = VEC_BASE + 4*i

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
irq  in  N_IRQ  interrupt request levels (rising edge latched)
irq_ack  out  N_IRQ  one-hot, one-cycle pulse when channel is taken
rom_addr  out  PC_W  equals pc
ex_pc  in  PC_W  next PC from execute
ex_reti  in  1  return-from-interrupt request
ex_ien_we  in  1  write interrupt enable
ex_ien  in  1  value for ex_ien_we
ex_w_req  in  1  execute wants an I/O write
ex_w_data  in  DATA_W  write data
w_req  out  1  I/O write strobe
w_data  out  DATA_W  I/O write data (pass-through of ex_w_data)
w_busy  in  1  I/O write side busy
r_data  in  DATA_W  I/O read data
commit  out  1  high in the cycle architectural state updates (register-file write enable qualifier)
pc, intr_pc  out  PC_W  current PC / saved return PC
intr_vec  out  3  index of last taken channel
intr_en  out  1  global interrupt enable
r_data_q  out  DATA_W  r_data sampled at last commit
w_busy_q  out  1  w_busy sampled at last commit
pending  out  N_IRQ  latched pending requests

Behaviour:
- Reset: all outputs and registers 0; phase = one-hot bit 0; irq edge-detect history = 0.
  - First commit occurs in the first cycle after reset deasserts.
- Phase counter:
  - PHASES-bit one-hot, rotates left each cycle.
  - commit_slot = phase[0].
  - commit = commit_slot & !stall.
- Stall:
  - stall = commit_slot & ex_w_req & w_busy (live input).
  - While stalled, phase holds at bit 0 and no state updates; w_req stays 0.
  - The slot retries every cycle until w_busy=0.
- w_req = commit & ex_w_req (one-cycle strobe).
- Pending (every cycle):
  - pending <= (pending & ~clear) | (irq & ~irq_d).
  - A new edge in the clear cycle keeps the bit set.
- Priority select: take = commit & intr_en & !ex_reti & |pending; idx = lowest set bit.
- On commit, exactly one case applies, in priority order:
  - ex_reti: pc<=intr_pc, intr_en<=1.
  - take:
    - pc<=VEC_BASE+4*idx; intr_pc<=ex_pc; intr_en<=0; intr_vec<=idx.
    - clear bit idx; irq_ack[idx]=1 in the same cycle as commit.
    - ex_ien_we is ignored.
  - otherwise: pc<=ex_pc; if ex_ien_we, intr_en<=ex_ien.
  - In all cases: r_data_q<=r_data, w_busy_q<=w_busy.
- An interrupt coinciding with a write commit is taken in that same commit, after the write strobe; intr_pc is ex_pc.
- ex_reti together with pending: reti wins; the interrupt is taken at the next commit.
- PC arithmetic wraps modulo 2^PC_W.
- Reset mid-stall or mid-phase: immediate return to reset state; pending edges are lost.

Test Plan:
- PHASES=4, reset release, ex_pc=pc+1 → commit at cycles 1,5,9; rom_addr 0,1,2; w_req never high.
- ex_w_req=1, ex_w_data=8'h41, w_busy high 6 cycles after commit slot → commit/w_req held low 6 cycles, then a single w_req pulse with w_data=8'h41; next commit 4 cycles later.
- intr_en=1, irq[2] and irq[1] rise in the same cycle, ex_pc=0x20 → next commit: pc=0x014, intr_pc=0x20, intr_vec=1, irq_ack=0010, pending=0100. Then ex_reti → pc=0x20, intr_en=1. Next commit: pc=0x018, irq_ack=0100.
- intr_en=0, irq[0] pulse → pending[0] held across commits. ex_ien_we=1, ex_ien=1 → intr_en=1. Following commit takes channel 0, pc=0x010.
- irq[3] rises in the exact cycle channel 3 is acked → pending[3] stays 1; taken again after reti.
- Reset asserted during stall with pending=1111 → next cycle: all outputs 0, phase=bit 0, no w_req.
